mat_op_sequencer: RTL and testbench
===================================

Name: mat_op_sequencer

Overview:
- Drives the 10-element dot-product MAC from matrix memories and computes C = A x B for 10x10 signed matrices.
- Fetches row i of A and column j of B from synchronous-read RAMs and presents them as parallel vectors.
- Pulses the MAC write enable, captures the MAC result, and writes it to C memory.
- Sits between the operand/result RAMs and the MAC in the matrix-multiply top level.

Parameters:
- N, 10, matrix dimension and MAC vector length.
- DW, 16, signed operand width.
- RW, 32, signed result width.
- AW, 7, RAM address width (covers N*N = 100 entries).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  begin full multiply; sampled only in IDLE.
- busy  out  1  high in FETCH, DRAIN, COMPUTE and WRITE.
- done  out  1  one-cycle pulse after the final C write.
- a_rd_en  out  1  A RAM read strobe.
- a_addr  out  AW  A address, row-major: i*N+k.
- a_rd_data  in  DW  A read data, valid 1 cycle after a_rd_en.
- b_rd_en  out  1  B RAM read strobe.
- b_addr  out  AW  B address: k*N+j.
- b_rd_data  in  DW  B read data, valid 1 cycle after b_rd_en.
- a_vec  out  N*DW  row operands; element k at [k*DW +: DW]; feeds MAC a_i_k.
- b_vec  out  N*DW  column operands; same packing; feeds MAC b_j_k.
- mac_w_en  out  1  MAC write enable.
- mac_r_ij  in  RW  MAC result.
- c_wr_en  out  1  C RAM write strobe.
- c_addr  out  AW  C address: i*N+j.
- c_wr_data  out  RW  C write data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; i, j, k = 0.
  - busy, done, a_rd_en, b_rd_en, mac_w_en, c_wr_en = 0.
  - All addresses, a_vec, b_vec and c_wr_data = 0.
- Reset mid-operation: abort immediately with no further RAM or MAC strobes. Partial C contents are don't-care. The next start recomputes from (0,0).
- States: IDLE, FETCH, DRAIN, COMPUTE, WRITE, DONE.
- IDLE -> FETCH on start=1. i, j, k cleared.
- FETCH, N cycles:
  - a_rd_en = b_rd_en = 1.
  - Addresses issued for k = 0..N-1.
  - Data returned for index k-1 is loaded into vector slot k-1.
  - After k = N-1 go to DRAIN.
- DRAIN, 1 cycle: no reads. Slot N-1 loaded. Go to COMPUTE.
- COMPUTE, 1 cycle: mac_w_en = 1; a_vec and b_vec stable. Go to WRITE.
- WRITE, 1 cycle:
  - c_wr_en = 1, c_addr = i*N+j, c_wr_data = mac_r_ij sampled this cycle.
  - a_vec and b_vec are still held stable.
  - Advance j; when j wraps N-1 -> 0, advance i.
  - If (i, j) was (N-1, N-1), go to DONE; else go to FETCH with k = 0.
- DONE, 1 cycle: done = 1, busy = 0. Go to IDLE.
- Latency:
  - Per element: N+3 = 13 cycles.
  - With start sampled at edge 0: first a_rd_en in cycle 1; first c_wr_en in cycle 13; last c_wr_en in cycle 1300; done in cycle 1301.
- start is ignored outside IDLE, including during DONE. Holding start high yields back-to-back runs separated by the IDLE cycle.
- Arithmetic: the block does no arithmetic on data. mac_r_ij is passed bit-exact, including MAC wrap-around. Address products use AW-bit unsigned math, max 99.
- a_vec and b_vec keep their last values in IDLE and DONE. They change only on FETCH/DRAIN loads or reset.

Decomposition:
- Shared package mat_pkg holds:
  - N, DW, RW, AW.
  - State encoding localparams.
  - The vector slice rule (k*DW +: DW), also used by the top-level MAC hookup.
- One sub-module, operand_loader: holds the registered a_vec and b_vec. It takes a load enable, slot index and two DW data words, and writes both vectors' slot on load. The FSM and i/j/k counters stay in mat_op_sequencer.

Test Plan:
- A = identity, B[k][j] = 10k+j, reference MAC model -> C[i][j] = 10i+j for all 100 entries; done at cycle 1301.
- A = B = all 1 -> every C = 10; 100 c_wr_en pulses, c_addr 0..99 in order.
- A = B = all -32768 -> every C = 32'h80000000 (-2147483648, MAC wrap passed through unchanged).
- Address trace for element (0,1):
  - a_addr 0..9;
  - b_addr 1, 11, ..., 91;
  - mac_w_en in cycle 25, c_wr_en with c_addr 1 in cycle 26.
- start held high for 3000 cycles -> exactly two done pulses (cycles 1301 and 2603); no strobes in the IDLE cycle between runs.
- rst=0 asserted mid-cycle at cycle 500 -> all outputs 0 immediately and no strobes until restart. Restart yields correct full C and done 1301 cycles after start.

Source files
------------

// File: rtl/mat_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mat_pkg
//  Description : Shared dimensions, FSM state encoding and index helpers for
//                the matrix-multiply operand sequencer and its MAC hookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package mat_pkg;

  localparam int N  = 10;               // matrix dimension / MAC vector length
  localparam int DW = 16;               // signed operand width
  localparam int RW = 32;               // signed result width
  localparam int AW = 7;                // RAM address width (N*N entries)
  localparam int KW = $clog2(N);        // width of the i/j/k counters

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_DRAIN   = ST_DRAIN,
    S_COMPUTE = ST_COMPUTE,
    S_WRITE   = ST_WRITE,
    S_DONE    = ST_DONE
  } state_t;

  // Element k of a packed operand vector lives at [vec_lsb(k) +: DW].
  function automatic int vec_lsb(input int k);
    return k * DW;
  endfunction

  // Row-major linear address row*N+col, evaluated in AW-bit unsigned math.
  function automatic logic [AW-1:0] lin_addr(input logic [KW-1:0] row,
                                             input logic [KW-1:0] col);
    return AW'(row) * AW'(N) + AW'(col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mat_op_sequencer_if
//  Description : Bundle between the sequencer and the A/B/C RAMs plus MAC.
//                master : sequencer side (drives strobes, addresses, vectors)
//                slave  : RAM/MAC side (returns read data and MAC result)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mat_op_sequencer_if;
  import mat_pkg::*;

  logic              a_rd_en;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_rd_data;
  logic              b_rd_en;
  logic [AW-1:0]     b_addr;
  logic [DW-1:0]     b_rd_data;
  logic [N*DW-1:0]   a_vec;
  logic [N*DW-1:0]   b_vec;
  logic              mac_w_en;
  logic [RW-1:0]     mac_r_ij;
  logic              c_wr_en;
  logic [AW-1:0]     c_addr;
  logic [RW-1:0]     c_wr_data;

  modport master (
    output a_rd_en, a_addr, b_rd_en, b_addr, a_vec, b_vec,
           mac_w_en, c_wr_en, c_addr, c_wr_data,
    input  a_rd_data, b_rd_data, mac_r_ij
  );

  modport slave (
    input  a_rd_en, a_addr, b_rd_en, b_addr, a_vec, b_vec,
           mac_w_en, c_wr_en, c_addr, c_wr_data,
    output a_rd_data, b_rd_data, mac_r_ij
  );

endinterface
`default_nettype wire

// File: rtl/mat_op_sequencer_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader
//  Description : Registered row (a_vec) and column (b_vec) operand vectors.
//                On load_i both vectors capture their data word into slot_i.
//  Ports       : clk, rst_n        clock, async active-low reset
//                load_i, slot_i    write enable and slot index
//                a_data_i/b_data_i words written into the slot
//                a_vec_o/b_vec_o   packed vectors, slot k at [k*DW +: DW]
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_loader
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [KW-1:0]     slot_i,
  input  logic [DW-1:0]     a_data_i,
  input  logic [DW-1:0]     b_data_i,
  output logic [N*DW-1:0]   a_vec_o,
  output logic [N*DW-1:0]   b_vec_o
);

  logic [N*DW-1:0] a_vec_q;
  logic [N*DW-1:0] b_vec_q;

  // Vectors are only written on a load, so they hold across IDLE/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vec_q <= '0;
      b_vec_q <= '0;
    end else if (load_i) begin
      a_vec_q[vec_lsb(int'(slot_i)) +: DW] <= a_data_i;
      b_vec_q[vec_lsb(int'(slot_i)) +: DW] <= b_data_i;
    end
  end

  assign a_vec_o = a_vec_q;
  assign b_vec_o = b_vec_q;

endmodule
`default_nettype wire

// File: rtl/mat_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mat_op_sequencer
//  Description : Walks C = A x B element by element. For each (i,j) it reads
//                row i of A and column j of B into parallel vectors, fires the
//                MAC, then writes the MAC result to C at i*N+j.
//  Ports       : clk, rst_n   clock, async active-low reset
//                start_i      begin a full multiply (sampled in IDLE only)
//                busy_o       high in FETCH/DRAIN/COMPUTE/WRITE
//                done_o       one-cycle pulse after the last C write
//                bus          RAM/MAC bundle (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_op_sequencer
  import mat_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  mat_op_sequencer_if.master   bus
);

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t          state_q, state_d;
  logic [KW-1:0]   i_q, i_d;
  logic [KW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic            load_d;
  logic [KW-1:0]   slot_d;
  logic [N*DW-1:0] vec_a;
  logic [N*DW-1:0] vec_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // All strobes and addresses decode from the state register, so an
  // asynchronous reset silences them immediately.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    load_d        = 1'b0;
    slot_d        = '0;
    bus.a_rd_en   = 1'b0;
    bus.b_rd_en   = 1'b0;
    bus.a_addr    = '0;
    bus.b_addr    = '0;
    bus.mac_w_en  = 1'b0;
    bus.c_wr_en   = 1'b0;
    bus.c_addr    = '0;
    bus.c_wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_FETCH: begin
        busy_o      = 1'b1;
        bus.a_rd_en = 1'b1;
        bus.b_rd_en = 1'b1;
        bus.a_addr  = lin_addr(i_q, k_q);
        bus.b_addr  = lin_addr(k_q, j_q);
        // RAM data lags the address by one cycle: capture word k-1 now.
        if (k_q != '0) begin
          load_d = 1'b1;
          slot_d = k_q - KW'(1);
        end
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        busy_o  = 1'b1;
        load_d  = 1'b1;
        slot_d  = K_LAST;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy_o       = 1'b1;
        bus.mac_w_en = 1'b1;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        busy_o        = 1'b1;
        bus.c_wr_en   = 1'b1;
        bus.c_addr    = lin_addr(i_q, j_q);
        bus.c_wr_data = bus.mac_r_ij;
        state_d       = S_FETCH;
        if (j_q == K_LAST) begin
          j_d = '0;
          if (i_q == K_LAST) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  operand_loader u_operand_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_d),
    .slot_i   (slot_d),
    .a_data_i (bus.a_rd_data),
    .b_data_i (bus.b_rd_data),
    .a_vec_o  (vec_a),
    .b_vec_o  (vec_b)
  );

  assign bus.a_vec = vec_a;
  assign bus.b_vec = vec_b;

endmodule
`default_nettype wire

// File: tb/tb_mat_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_op_sequencer
//  Description : Directed bench for mat_op_sequencer with behavioural A/B RAMs,
//                a registered 10-element MAC and a C-write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  mat_op_sequencer_if bus ();

  mat_op_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = -100000;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM and MAC models ----------------
  logic [15:0] a_mem [100];
  logic [15:0] b_mem [100];

  always @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rd_data <= a_mem[bus.a_addr];
    if (bus.b_rd_en) bus.b_rd_data <= b_mem[bus.b_addr];
  end

  function automatic logic [31:0] mac_fn(input logic [159:0] av, input logic [159:0] bv);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 10; k++)
      acc = acc + 32'($signed(av[k*16 +: 16])) * 32'($signed(bv[k*16 +: 16]));
    return acc;
  endfunction

  always @(posedge clk)
    if (bus.mac_w_en) bus.mac_r_ij <= mac_fn(bus.a_vec, bus.b_vec);

  // ---------------- monitor ----------------
  logic [31:0] c_got [100];
  int wr_cnt, order_err, first_wr, last_wr;
  int done_cnt, done_c0, done_c1, idle_strobe;
  int tr_a [32];
  int tr_b [32];
  int tr_caddr [32];
  bit tr_mac [32];
  bit tr_cwe [32];

  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (bus.c_wr_en) begin
      if (int'(bus.c_addr) != (wr_cnt % 100)) order_err++;
      if (bus.c_addr < 7'd100) c_got[bus.c_addr] = bus.c_wr_data;
      if (wr_cnt == 0) first_wr = rel;
      last_wr = rel;
      wr_cnt++;
    end
    if (done) begin
      if (done_cnt == 0) done_c0 = rel;
      else if (done_cnt == 1) done_c1 = rel;
      done_cnt++;
    end
    if (!busy && !done &&
        (bus.a_rd_en || bus.b_rd_en || bus.mac_w_en || bus.c_wr_en))
      idle_strobe++;
    if (rel >= 0 && rel < 32) begin
      tr_a[rel]     = int'(bus.a_addr);
      tr_b[rel]     = int'(bus.b_addr);
      tr_caddr[rel] = int'(bus.c_addr);
      tr_mac[rel]   = bus.mac_w_en;
      tr_cwe[rel]   = bus.c_wr_en;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic mon_clear();
    wr_cnt = 0; order_err = 0; first_wr = -1; last_wr = -1;
    done_cnt = 0; done_c0 = -1; done_c1 = -1; idle_strobe = 0;
    for (int n = 0; n < 100; n++) c_got[n] = 32'hDEAD_BEEF;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      160'(busy),          160'd0);
    chk({tag, ".done"},      160'(done),          160'd0);
    chk({tag, ".strobes"},   160'({bus.a_rd_en, bus.b_rd_en, bus.mac_w_en, bus.c_wr_en}), 160'd0);
    chk({tag, ".addrs"},     160'({bus.a_addr, bus.b_addr, bus.c_addr}), 160'd0);
    chk({tag, ".c_wr_data"}, 160'(bus.c_wr_data), 160'd0);
    chk({tag, ".a_vec"},     bus.a_vec,           160'd0);
    chk({tag, ".b_vec"},     bus.b_vec,           160'd0);
  endtask

  // pat 1: A=identity, B[k][j]=10k+j ; pat 2: all ones ; pat 3: all -32768
  task automatic load_mats(input int pat);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        case (pat)
          1: begin a_mem[r*10+c] = (r == c) ? 16'd1 : 16'd0; b_mem[r*10+c] = 16'(10*r + c); end
          2: begin a_mem[r*10+c] = 16'd1;    b_mem[r*10+c] = 16'd1;    end
          default: begin a_mem[r*10+c] = 16'h8000; b_mem[r*10+c] = 16'h8000; end
        endcase
      end
  endtask

  function automatic logic [31:0] exp_c(input int pat, input int r, input int c);
    case (pat)
      1: return 32'(10*r + c);
      2: return 32'd10;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic do_run(input int pat, input string tag);
    mon_clear();
    @(negedge clk); start = 1'b1; base = cyc;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 1400; n++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    chk({tag, ".done_cnt"},   160'(done_cnt),  160'd1);
    chk({tag, ".done_cycle"}, 160'(done_c0),   160'd1301);
    chk({tag, ".wr_cnt"},     160'(wr_cnt),    160'd100);
    chk({tag, ".order"},      160'(order_err), 160'd0);
    chk({tag, ".first_wr"},   160'(first_wr),  160'd13);
    chk({tag, ".last_wr"},    160'(last_wr),   160'd1300);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        chk($sformatf("%s.C[%0d][%0d]", tag, r, c), 160'(c_got[r*10+c]), 160'(exp_c(pat, r, c)));
  endtask

  logic [159:0] exp_bvec;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mon_clear();
    load_mats(1);
    repeat (3) @(negedge clk);
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle_after_reset");

    // identity x B, plus address/strobe trace of element (0,1)
    do_run(1, "ident");
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("trace.a_addr[%0d]", k), 160'(tr_a[14+k]), 160'(k));
      chk($sformatf("trace.b_addr[%0d]", k), 160'(tr_b[14+k]), 160'(1 + 10*k));
    end
    chk("trace.mac_w_en_c24", 160'(tr_mac[24]),   160'd0);
    chk("trace.mac_w_en_c25", 160'(tr_mac[25]),   160'd1);
    chk("trace.c_wr_en_c26",  160'(tr_cwe[26]),   160'd1);
    chk("trace.c_addr_c26",   160'(tr_caddr[26]), 160'd1);
    // vectors hold row 9 / column 9 after the run
    exp_bvec = '0;
    for (int k = 0; k < 10; k++) exp_bvec[k*16 +: 16] = 16'(10*k + 9);
    chk("hold.a_vec", bus.a_vec, 160'd1 << 144);
    chk("hold.b_vec", bus.b_vec, exp_bvec);

    load_mats(2);
    do_run(2, "ones");
    load_mats(3);
    do_run(3, "neg");

    // start held high: back-to-back runs
    load_mats(2);
    mon_clear();
    @(negedge clk); start = 1'b1; base = cyc;
    repeat (3000) @(negedge clk);
    chk("held.done_cnt", 160'(done_cnt),    160'd2);
    chk("held.done0",    160'(done_c0),     160'd1301);
    chk("held.done1",    160'(done_c1),     160'd2603);
    chk("held.idle_str", 160'(idle_strobe), 160'd0);
    start = 1'b0;

    // abort the third run, then mid-cycle reset test
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_mats(1);
    @(negedge clk); start = 1'b1; base = cyc;
    @(negedge clk); start = 1'b0;
    repeat (499) @(negedge clk);
    chk("mid.busy_before", 160'(busy), 160'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_clear();
    repeat (5) @(negedge clk);
    chk("post_reset.strobes", 160'(idle_strobe), 160'd0);
    chk("post_reset.busy",    160'(busy),        160'd0);
    do_run(1, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
